fifo_param: RTL and testbench

FIFO_PARAM -- requirements
Module: fifo_param

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_mem.sv | 24 ++
 rtl/fifo_param.sv | 110 +++++++++++
 tb/tb_fifo_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared defaults and status-flag bundle for the parameterised FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_DEPTH      = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostfull;
    logic almostempty;
    logic overflow;
    logic underflow;
    logic wr_ack;
  } fifo_status_t;

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: DEPTH x DATA_WIDTH, one synchronous write port, one asynchronous read port.
module fifo_mem #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  // Not reset: stale words are unreachable once the pointers are equal.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_param.sv
// Parameterised synchronous FIFO with occupancy count and status flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered read.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic                         rd_en,
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic                         wr_ack,
  output logic                         overflow,
  output logic                         underflow,
  output logic                         full,
  output logic                         empty,
  output logic                         almostfull,
  output logic                         almostempty,
  output logic [$clog2(DEPTH+1)-1:0]   data_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || AE_THRESH < 0 || AE_THRESH >= AF_THRESH || AF_THRESH > DEPTH) begin : g_bad_params
    $fatal(1, "fifo_param: need DEPTH>=2 and 0<=AE_THRESH<AF_THRESH<=DEPTH");
  end

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  ack_q, ovf_q, udf_q;
  logic                  wr_ok, rd_ok;
  logic [DATA_WIDTH-1:0] head;
  fifo_status_t          st;

  always_comb begin
    st             = '0;
    st.full        = (count == CW'(DEPTH));
    st.empty       = (count == '0);
    st.almostfull  = (count >= CW'(AF_THRESH));
    st.almostempty = (count != '0) && (count <= CW'(AE_THRESH));
    st.wr_ack      = ack_q;
    st.overflow    = ovf_q;
    st.underflow   = udf_q;
  end

  // Blocking is decided purely by the current count, so full+both does a read
  // only and empty+both does a write only.
  assign wr_ok = wr_en && !st.full;
  assign rd_ok = rd_en && !st.empty;

  fifo_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .we    (wr_ok && !rst),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ack_q  <= 1'b0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      ack_q <= wr_ok;
      ovf_q <= wr_en && !wr_ok;
      udf_q <= rd_en && !rd_ok;
    end
  end

`ifdef FIFO_FWFT_EN
  assign data_out = st.empty ? '0 : head;
`else
  logic [DATA_WIDTH-1:0] dout_q;

  always_ff @(posedge clk) begin
    if (rst)        dout_q <= '0;
    else if (rd_ok) dout_q <= head;
  end

  assign data_out = dout_q;
`endif

  assign data_count  = count;
  assign full        = st.full;
  assign empty       = st.empty;
  assign almostfull  = st.almostfull;
  assign almostempty = st.almostempty;
  assign wr_ack      = st.wr_ack;
  assign overflow    = st.overflow;
  assign underflow   = st.underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (standard registered-read mode), queue-based reference model.
module tb_fifo_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0, rd_en = 1'b0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [3:0]  data_count;

  int errors = 0;
  int checks = 0;

  // Reference model: occupancy is the queue size, data order is queue order.
  logic [15:0] mq[$];
  logic [15:0] exp_dout = '0;
  logic        exp_ack = 1'b0, exp_ovf = 1'b0, exp_udf = 1'b0;

  fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AF_THRESH(7), .AE_THRESH(1)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty),
    .data_count  (data_count)
  );

  always #5 clk = ~clk;

  // Drive one cycle and advance the model; outputs are sampled 1 time unit after the edge.
  task automatic drive(input logic w, input logic r, input logic [15:0] d);
    logic wa, ra;
    wr_en = w; rd_en = r; data_in = d;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      exp_dout = '0; exp_ack = 0; exp_ovf = 0; exp_udf = 0;
    end else begin
      wa = w && (mq.size() < 8);
      ra = r && (mq.size() > 0);
      if (ra) exp_dout = mq.pop_front();
      if (wa) mq.push_back(d);
      exp_ack = wa;
      exp_ovf = w && !wa;
      exp_udf = r && !ra;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1, 1, 16'h1234);
    drive(0, 0, 0);
    rst = 1'b0;
    checks++;
    if ({data_count, empty, full, almostfull, almostempty, wr_ack, overflow, underflow} !== {4'd0, 7'b1000000}) begin
      errors++;
      $display("FAIL reset_flags: got cnt=%0d e=%b f=%b af=%b ae=%b ack=%b ovf=%b udf=%b, want cnt=0 e=1 rest 0",
               data_count, empty, full, almostfull, almostempty, wr_ack, overflow, underflow);
    end
    checks++;
    if (data_out !== 16'h0) begin errors++; $display("FAIL reset_dout: got %h want 0000", data_out); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 16'(i));
      checks++;
      if (wr_ack !== 1'b1 || data_count !== 4'(i + 1)) begin
        errors++; $display("FAIL fill_ack[%0d]: ack=%b cnt=%0d want ack=1 cnt=%0d", i, wr_ack, data_count, i + 1);
      end
      checks++;
      if (almostfull !== (i + 1 >= 7) || full !== (i + 1 == 8)) begin
        errors++; $display("FAIL fill_flags[%0d]: af=%b f=%b want af=%b f=%b", i, almostfull, full, i + 1 >= 7, i + 1 == 8);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1, 0, 16'd8);
    checks++;
    if (overflow !== 1'b1 || wr_ack !== 1'b0 || data_count !== 4'd8) begin
      errors++; $display("FAIL overflow: ovf=%b ack=%b cnt=%0d want 1 0 8", overflow, wr_ack, data_count);
    end
    drive(0, 0, 0);
    checks++;
    if (overflow !== 1'b0) begin errors++; $display("FAIL overflow_pulse: ovf=%b want 0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0);
      checks++;
      if (data_out !== 16'(i) || data_count !== 4'(7 - i)) begin
        errors++; $display("FAIL drain[%0d]: dout=%0d cnt=%0d want %0d %0d", i, data_out, data_count, i, 7 - i);
      end
      checks++;
      if (almostempty !== (7 - i == 1) || empty !== (7 - i == 0)) begin
        errors++; $display("FAIL drain_flags[%0d]: ae=%b e=%b want %b %b", i, almostempty, empty, 7 - i == 1, 7 - i == 0);
      end
    end
  endtask

  task automatic test_underflow();
    drive(0, 1, 0);
    checks++;
    if (underflow !== 1'b1 || data_out !== 16'd7 || data_count !== 4'd0) begin
      errors++; $display("FAIL underflow: udf=%b dout=%0d cnt=%0d want 1 7 0", underflow, data_out, data_count);
    end
    drive(0, 0, 0);
    checks++;
    if (underflow !== 1'b0 || data_out !== 16'd7) begin
      errors++; $display("FAIL underflow_pulse: udf=%b dout=%0d want 0 7", underflow, data_out);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 3; i++) drive(1, 0, 16'(100 + i));
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 16'(200 + i));
      checks++;
      if (data_count !== 4'd3 || wr_ack !== 1'b1 || data_out !== exp_dout) begin
        errors++; $display("FAIL simul[%0d]: cnt=%0d ack=%b dout=%0d want 3 1 %0d", i, data_count, wr_ack, data_out, exp_dout);
      end
    end
    for (int i = 0; i < 5; i++) drive(1, 0, 16'(300 + i));
    drive(1, 1, 16'hAAAA);
    checks++;
    if (data_count !== 4'd7 || overflow !== 1'b1 || wr_ack !== 1'b0 || data_out !== exp_dout) begin
      errors++; $display("FAIL simul_full: cnt=%0d ovf=%b ack=%b dout=%0d want 7 1 0 %0d", data_count, overflow, wr_ack, data_out, exp_dout);
    end
    while (mq.size() > 0) drive(0, 1, 0);
    drive(1, 1, 16'h5555);
    checks++;
    if (data_count !== 4'd1 || underflow !== 1'b1 || wr_ack !== 1'b1 || data_out !== exp_dout) begin
      errors++; $display("FAIL simul_empty: cnt=%0d udf=%b ack=%b dout=%0d want 1 1 1 %0d", data_count, underflow, wr_ack, data_out, exp_dout);
    end
    drive(0, 1, 0);
    checks++;
    if (data_out !== 16'h5555) begin errors++; $display("FAIL simul_empty_data: dout=%h want 5555", data_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 16'($urandom));
      checks++;
      if (data_out !== exp_dout || data_count !== 4'(mq.size()) || wr_ack !== exp_ack ||
          overflow !== exp_ovf || underflow !== exp_udf ||
          full !== (mq.size() == 8) || empty !== (mq.size() == 0) ||
          almostfull !== (mq.size() >= 7) || almostempty !== (mq.size() == 1)) begin
        errors++;
        $display("FAIL random[%0d]: dout=%h cnt=%0d ack=%b ovf=%b udf=%b f=%b e=%b af=%b ae=%b want dout=%h cnt=%0d ack=%b ovf=%b udf=%b",
                 i, data_out, data_count, wr_ack, overflow, underflow, full, empty, almostfull, almostempty,
                 exp_dout, mq.size(), exp_ack, exp_ovf, exp_udf);
      end
    end
  endtask

  task automatic test_reset_mid();
    while (mq.size() > 0) drive(0, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 16'(40 + i));
    checks++;
    if (data_count !== 4'd5) begin errors++; $display("FAIL reset_mid_pre: cnt=%0d want 5", data_count); end
    rst = 1'b1;
    drive(1, 0, 16'h7777);
    rst = 1'b0;
    checks++;
    if (data_count !== 4'd0 || empty !== 1'b1 || data_out !== 16'h0 || wr_ack !== 1'b0) begin
      errors++; $display("FAIL reset_mid: cnt=%0d e=%b dout=%h ack=%b want 0 1 0000 0", data_count, empty, data_out, wr_ack);
    end
    drive(1, 0, 16'hBEEF);
    drive(0, 1, 0);
    checks++;
    if (data_out !== 16'hBEEF || empty !== 1'b1) begin
      errors++; $display("FAIL reset_mid_write: dout=%h e=%b want beef 1", data_out, empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_simultaneous();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
